// File: rtl/menu_controller.sv
`default_nettype none
// ============================================================================
// Module      : menu_controller
// Description : Front-panel sequencer. Conditions three active-low push-buttons
//               (2-FF synchroniser + debounce, auto-repeat on UP/DOWN), walks
//               the menu state machine, edits temperature / humidity setpoints,
//               time of day and sunrise time, runs the time-of-day clock from a
//               one-minute tick, and returns to IDLE after inactivity.
// Ports       : CLOCK_50        system clock
//               RESET_N         synchronous active-low reset
//               KEY_NEXT/UP/DOWN raw asynchronous active-low buttons
//               MINUTE_TICK     one-cycle pulse per minute
//               MENU_STATE      current menu state (0..6)
//               SET_TEMP_F      temperature setpoint, degrees F
//               SET_HUM         humidity setpoint, %
//               TIME_HOURS/MINUTES, SUNRISE_HOURS/MINUTES  clock fields
// Revision    : 1.0 - initial release
// ============================================================================
module menu_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int TIMEOUT_CYCLES  = 500000000,
    parameter int TEMP_MIN        = 40,
    parameter int TEMP_MAX        = 100,
    parameter int TEMP_DEFAULT    = 75,
    parameter int HUM_MIN         = 0,
    parameter int HUM_MAX         = 100,
    parameter int HUM_DEFAULT     = 50
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        KEY_NEXT,
    input  logic        KEY_UP,
    input  logic        KEY_DOWN,
    input  logic        MINUTE_TICK,
    output logic [3:0]  MENU_STATE,
    output logic [11:0] SET_TEMP_F,
    output logic [7:0]  SET_HUM,
    output logic [4:0]  TIME_HOURS,
    output logic [5:0]  TIME_MINUTES,
    output logic [4:0]  SUNRISE_HOURS,
    output logic [5:0]  SUNRISE_MINUTES
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_TEMP   = 4'd1,
        ST_HUM    = 4'd2,
        ST_TIME_H = 4'd3,
        ST_TIME_M = 4'd4,
        ST_SUN_H  = 4'd5,
        ST_SUN_M  = 4'd6
    } menu_state_t;

    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0] c_db_last     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] c_delay_last  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] c_period_last = RP_W'(REPEAT_PERIOD - 1);
    localparam logic [TO_W-1:0] c_to_limit    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [11:0]     c_temp_min    = 12'(TEMP_MIN);
    localparam logic [11:0]     c_temp_max    = 12'(TEMP_MAX);
    localparam logic [11:0]     c_temp_def    = 12'(TEMP_DEFAULT);
    localparam logic [7:0]      c_hum_min     = 8'(HUM_MIN);
    localparam logic [7:0]      c_hum_max     = 8'(HUM_MAX);
    localparam logic [7:0]      c_hum_def     = 8'(HUM_DEFAULT);

    // Key index: 0 = NEXT, 1 = UP, 2 = DOWN
    logic [2:0] key_raw;
    logic [2:0] press_evt;
    logic [2:0] rep_evt;

    assign key_raw = {KEY_DOWN, KEY_UP, KEY_NEXT};

    for (genvar i = 0; i < 3; i++) begin : g_key
        logic            sync1_q;
        logic            sync2_q;
        logic            deb_q;     // debounced level, 1 = pressed
        logic            deb_d;
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            armed_q;   // key has been seen released since reset
        logic            armed_d;
        logic            press_q;
        logic            press_d;

        always_comb begin
            deb_d    = deb_q;
            db_cnt_d = '0;
            if ((~sync2_q) != deb_q) begin
                if (db_cnt_q == c_db_last) begin
                    deb_d = ~sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            // A key held through reset must be released before it can
            // produce any event, so arming waits for a released level.
            armed_d = armed_q | (~deb_q & sync2_q);
            press_d = deb_d & ~deb_q & armed_q;
        end

        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                // Synchronisers start at the pressed level so a key already
                // held low at reset never looks like a fresh release.
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                deb_q    <= 1'b0;
                db_cnt_q <= '0;
                armed_q  <= 1'b0;
                press_q  <= 1'b0;
            end else begin
                sync1_q  <= key_raw[i];
                sync2_q  <= sync1_q;
                deb_q    <= deb_d;
                db_cnt_q <= db_cnt_d;
                armed_q  <= armed_d;
                press_q  <= press_d;
            end
        end

        assign press_evt[i] = press_q;

        if (i == 0) begin : g_no_repeat
            assign rep_evt[i] = 1'b0;
        end else begin : g_repeat
            logic [RP_W-1:0] rep_cnt_q;
            logic [RP_W-1:0] rep_cnt_d;
            logic            rep_done_q;  // initial delay has elapsed
            logic            rep_done_d;
            logic            rep_q;
            logic            rep_d;

            always_comb begin
                rep_cnt_d  = '0;
                rep_done_d = 1'b0;
                rep_d      = 1'b0;
                if (deb_q && armed_q) begin
                    rep_done_d = rep_done_q;
                    if (rep_cnt_q == (rep_done_q ? c_period_last : c_delay_last)) begin
                        rep_d      = 1'b1;
                        rep_done_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge CLOCK_50) begin
                if (!RESET_N) begin
                    rep_cnt_q  <= '0;
                    rep_done_q <= 1'b0;
                    rep_q      <= 1'b0;
                end else begin
                    rep_cnt_q  <= rep_cnt_d;
                    rep_done_q <= rep_done_d;
                    rep_q      <= rep_d;
                end
            end

            assign rep_evt[i] = rep_q;
        end
    end

    logic next_evt;
    logic up_evt;
    logic down_evt;
    logic any_evt;

    // NEXT never auto-repeats; its repeat slot is tied low.
    assign next_evt = press_evt[0] | rep_evt[0];
    assign up_evt   = press_evt[1] | rep_evt[1];
    assign down_evt = press_evt[2] | rep_evt[2];
    assign any_evt  = next_evt | up_evt | down_evt;

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
        return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] minute_step(input logic [5:0] m, input logic up);
        if (up) return (m == 6'd59) ? 6'd0 : m + 6'd1;
        return (m == 6'd0) ? 6'd59 : m - 6'd1;
    endfunction

    menu_state_t     state_q, state_d;
    logic [11:0]     temp_q, temp_d;
    logic [7:0]      hum_q, hum_d;
    logic [4:0]      time_h_q, time_h_d;
    logic [5:0]      time_m_q, time_m_d;
    logic [4:0]      sun_h_q, sun_h_d;
    logic [5:0]      sun_m_q, sun_m_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        state_d  = state_q;
        temp_d   = temp_q;
        hum_d    = hum_q;
        time_h_d = time_h_q;
        time_m_d = time_m_q;
        sun_h_d  = sun_h_q;
        sun_m_d  = sun_m_q;
        to_cnt_d = to_cnt_q;

        // NEXT has priority; UP together with DOWN cancels out.
        if (next_evt) begin
            state_d = (state_q == ST_SUN_M) ? ST_IDLE : menu_state_t'(state_q + 4'd1);
        end else if (up_evt ^ down_evt) begin
            case (state_q)
                ST_TEMP: begin
                    if (up_evt) begin
                        if (temp_q < c_temp_max) temp_d = temp_q + 12'd1;
                    end else if (temp_q > c_temp_min) begin
                        temp_d = temp_q - 12'd1;
                    end
                end
                ST_HUM: begin
                    if (up_evt) begin
                        if (hum_q < c_hum_max) hum_d = hum_q + 8'd1;
                    end else if (hum_q > c_hum_min) begin
                        hum_d = hum_q - 8'd1;
                    end
                end
                ST_TIME_H: time_h_d = hour_step(time_h_q, up_evt);
                ST_TIME_M: time_m_d = minute_step(time_m_q, up_evt);
                ST_SUN_H:  sun_h_d  = hour_step(sun_h_q, up_evt);
                ST_SUN_M:  sun_m_d  = minute_step(sun_m_q, up_evt);
                default:   ;
            endcase
        end

        // The running clock stays frozen while its fields are being edited.
        if (MINUTE_TICK && (state_q != ST_TIME_H) && (state_q != ST_TIME_M)) begin
            time_m_d = minute_step(time_m_q, 1'b1);
            if (time_m_q == 6'd59) time_h_d = hour_step(time_h_q, 1'b1);
        end

        if ((state_q == ST_IDLE) || any_evt) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == c_to_limit) begin
            to_cnt_d = '0;
            state_d  = ST_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            temp_q   <= c_temp_def;
            hum_q    <= c_hum_def;
            time_h_q <= 5'd12;
            time_m_q <= 6'd0;
            sun_h_q  <= 5'd6;
            sun_m_q  <= 6'd0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            temp_q   <= temp_d;
            hum_q    <= hum_d;
            time_h_q <= time_h_d;
            time_m_q <= time_m_d;
            sun_h_q  <= sun_h_d;
            sun_m_q  <= sun_m_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign MENU_STATE      = state_q;
    assign SET_TEMP_F      = temp_q;
    assign SET_HUM         = hum_q;
    assign TIME_HOURS      = time_h_q;
    assign TIME_MINUTES    = time_m_q;
    assign SUNRISE_HOURS   = sun_h_q;
    assign SUNRISE_MINUTES = sun_m_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_controller
// Description : Self-checking bench for menu_controller. Table of button /
//               tick vectors with hand-computed expected outputs, plus
//               hand-written sequences for debounce latency, auto-repeat,
//               hour wrap by repeat, timeout and reset-while-held.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_next;
    logic        key_up;
    logic        key_down;
    logic        tick;
    logic [3:0]  menu_state;
    logic [11:0] set_temp;
    logic [7:0]  set_hum;
    logic [4:0]  time_h;
    logic [5:0]  time_m;
    logic [4:0]  sun_h;
    logic [5:0]  sun_m;

    always #5 clk = ~clk;

    menu_controller #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5),
        .TIMEOUT_CYCLES  (200)
    ) dut (
        .CLOCK_50        (clk),
        .RESET_N         (rst_n),
        .KEY_NEXT        (key_next),
        .KEY_UP          (key_up),
        .KEY_DOWN        (key_down),
        .MINUTE_TICK     (tick),
        .MENU_STATE      (menu_state),
        .SET_TEMP_F      (set_temp),
        .SET_HUM         (set_hum),
        .TIME_HOURS      (time_h),
        .TIME_MINUTES    (time_m),
        .SUNRISE_HOURS   (sun_h),
        .SUNRISE_MINUTES (sun_m)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] keys;   // bit0 NEXT, bit1 UP, bit2 DOWN (1 = press)
        logic       tick;
        int st, temp, hum, th, tm, sh, sm;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] N = 3'b001;
    localparam logic [2:0] U = 3'b010;
    localparam logic [2:0] D = 3'b100;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int temp, input int hum,
                           input int th, input int tm, input int sh, input int sm);
        chk({tag, " state"},   int'(menu_state), st);
        chk({tag, " temp"},    int'(set_temp),   temp);
        chk({tag, " hum"},     int'(set_hum),    hum);
        chk({tag, " time_h"},  int'(time_h),     th);
        chk({tag, " time_m"},  int'(time_m),     tm);
        chk({tag, " sun_h"},   int'(sun_h),      sh);
        chk({tag, " sun_m"},   int'(sun_m),      sm);
    endtask

    task automatic add(input logic [2:0] k, input logic t, input int st, input int temp,
                       input int hum, input int th, input int tm, input int sh, input int sm);
        vec_t v;
        v.keys = k; v.tick = t; v.st = st; v.temp = temp; v.hum = hum;
        v.th = th; v.tm = tm; v.sh = sh; v.sm = sm;
        vecs.push_back(v);
    endtask

    // Press for 10 cycles, optional tick aligned with the press event, settle.
    task automatic apply(input logic [2:0] k, input logic t);
        @(negedge clk);
        key_next = ~k[0];
        key_up   = ~k[1];
        key_down = ~k[2];
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 6) tick = t;
            if (c == 7) tick = 1'b0;
            if (c == 10) begin
                key_next = 1'b1;
                key_up   = 1'b1;
                key_down = 1'b1;
            end
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply(vecs[i].keys, vecs[i].tick);
            chk_all($sformatf("row%0d", i), vecs[i].st, vecs[i].temp, vecs[i].hum,
                    vecs[i].th, vecs[i].tm, vecs[i].sh, vecs[i].sm);
        end
    endtask

    // Output updates caused by a key held from cycle 0: first at 7, then 27,
    // then every 5; updates after 'last' do not happen.
    function automatic int rep_events(input int k, input int last);
        int n;
        int lim;
        n   = 0;
        lim = (k < last) ? k : last;
        if (lim >= 7)  n = 1;
        if (lim >= 27) n = n + 1 + (lim - 27) / 5;
        return n;
    endfunction

    initial begin
        // Expected results: state, temp, hum, time h:m, sunrise h:m
        add(D,     0, 1,  99, 50, 12,  0, 6,  0);  // 0
        add(N | U, 0, 2,  99, 50, 12,  0, 6,  0);  // 1 NEXT beats UP
        add(U | D, 0, 2,  99, 50, 12,  0, 6,  0);  // 2 UP+DOWN cancel
        add(U,     1, 2,  99, 51, 12,  1, 6,  0);  // 3 step + tick same cycle
        add(D,     0, 2,  99, 50, 12,  1, 6,  0);  // 4
        add(N,     0, 3,  99, 50, 12,  1, 6,  0);  // 5
        add(0,     1, 3,  99, 50, 12,  1, 6,  0);  // 6 tick ignored in TIME_H
        add(U,     0, 3,  99, 50, 13,  1, 6,  0);  // 7
        add(D,     0, 3,  99, 50, 12,  1, 6,  0);  // 8
        add(N,     0, 4,  99, 50, 12,  1, 6,  0);  // 9
        add(U,     0, 4,  99, 50, 12,  2, 6,  0);  // 10
        add(D,     0, 4,  99, 50, 12,  1, 6,  0);  // 11
        add(D,     0, 4,  99, 50, 12,  0, 6,  0);  // 12
        add(D,     0, 4,  99, 50, 12, 59, 6,  0);  // 13 wrap, no borrow
        add(U,     0, 4,  99, 50, 12,  0, 6,  0);  // 14 wrap, no carry
        add(0,     1, 4,  99, 50, 12,  0, 6,  0);  // 15 tick ignored in TIME_M
        add(N,     0, 5,  99, 50, 12,  0, 6,  0);  // 16
        add(U,     0, 5,  99, 50, 12,  0, 7,  0);  // 17
        add(N,     0, 6,  99, 50, 12,  0, 7,  0);  // 18
        add(D,     0, 6,  99, 50, 12,  0, 7, 59);  // 19
        add(U,     0, 6,  99, 50, 12,  0, 7,  0);  // 20
        add(D,     0, 6,  99, 50, 12,  0, 7, 59);  // 21
        add(N,     0, 0,  99, 50, 12,  0, 7, 59);  // 22 6 -> 0
        add(U,     0, 0,  99, 50, 12,  0, 7, 59);  // 23 ignored in IDLE
        add(0,     1, 0,  99, 50, 12,  1, 7, 59);  // 24 tick in IDLE
        add(N,     0, 1,  99, 50, 12,  1, 7, 59);  // 25
        add(N,     0, 2,  99, 50, 12,  1, 7, 59);  // 26
        add(N,     0, 3,  99, 50, 12,  1, 7, 59);  // 27
        add(N,     0, 4,  99, 50, 23,  1, 7, 59);  // 28 after hold-down wrap
        add(D,     0, 4,  99, 50, 23,  0, 7, 59);  // 29
        add(D,     0, 4,  99, 50, 23, 59, 7, 59);  // 30
        add(N,     0, 5,  99, 50, 23, 59, 7, 59);  // 31
        add(N,     0, 6,  99, 50, 23, 59, 7, 59);  // 32
        add(N,     0, 0,  99, 50, 23, 59, 7, 59);  // 33
        add(0,     1, 0,  99, 50,  0,  0, 7, 59);  // 34 23:59 -> 0:00
        add(N,     0, 1,  99, 50,  0,  0, 7, 59);  // 35
        add(N,     0, 2,  99, 50,  0,  0, 7, 59);  // 36
        add(N,     0, 3,  99, 50,  0,  0, 7, 59);  // 37
        add(N,     0, 4,  99, 50,  0,  0, 7, 59);  // 38
        add(N,     0, 5,  99, 50,  0,  0, 7, 59);  // 39
        add(U,     0, 5,  99, 50,  0,  0, 8, 59);  // 40
        add(N,     0, 1,  99, 50,  0,  0, 8, 59);  // 41 (after timeout)
        add(U,     0, 1,  76, 50, 12,  0, 6,  0);  // 42 (after reset)

        rst_n    = 1'b0;
        key_next = 1'b1;
        key_up   = 1'b1;
        key_down = 1'b1;
        tick     = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 75, 50, 12, 0, 6, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Debounce: 3-cycle glitch ignored, clean press lands 7 cycles later
        key_next = 1'b0;
        repeat (3) @(negedge clk);
        key_next = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch state", int'(menu_state), 0);
        key_next = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 6) chk("press latency 6", int'(menu_state), 0);
            if (c == 7) chk("press latency 7", int'(menu_state), 1);
            if (c == 10) key_next = 1'b1;
        end

        // Auto-repeat with saturation at TEMP_MAX
        key_up = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            int e;
            @(negedge clk);
            e = 75 + rep_events(k, 1000);
            if (e > 100) e = 100;
            chk($sformatf("repeat temp k%0d", k), int'(set_temp), e);
        end
        key_up = 1'b1;
        repeat (20) @(negedge clk);

        run_rows(0, 27);

        // Hold DOWN in TIME_H: 13 steps take 12 down through 0 to 23
        key_down = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            chk($sformatf("hold down hours k%0d", k), int'(time_h),
                ((12 - rep_events(k, 82)) + 24) % 24);
            if (k == 78) key_down = 1'b1;
        end
        repeat (20) @(negedge clk);

        run_rows(28, 40);

        // Inactivity timeout from SUN_H keeps the edited sunrise value
        repeat (180) @(negedge clk);
        chk("before timeout state", int'(menu_state), 5);
        repeat (15) @(negedge clk);
        chk("after timeout state", int'(menu_state), 0);
        chk("after timeout sun_h", int'(sun_h), 8);

        run_rows(41, 41);

        // Reset while UP is held: values restored, held key stays silent
        key_up = 1'b0;
        repeat (30) @(negedge clk);
        chk("held before reset temp", int'(set_temp), 100);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all("mid reset", 0, 75, 50, 12, 0, 6, 0);
        repeat (10) @(negedge clk);
        key_next = 1'b0;
        repeat (10) @(negedge clk);
        key_next = 1'b1;
        repeat (60) @(negedge clk);
        chk("held after reset state", int'(menu_state), 1);
        chk("held after reset temp", int'(set_temp), 75);
        key_up = 1'b1;
        repeat (20) @(negedge clk);

        run_rows(42, 42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
